// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the multi-operand Stein GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ACK
  } state_t;

  localparam int CW_DEFAULT = 8;

  // Shift count must reach W-1 common factors of two, plus headroom.
  function automatic int k_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational step of the binary (Stein) GCD algorithm.
module gcd_stein_step #(
  parameter int W  = 16,
  parameter int KW = 5
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  a_next,
  output logic [W-1:0]  b_next,
  output logic [KW-1:0] k_next,
  output logic          done,
  output logic [W-1:0]  result
);

  always_comb begin
    a_next = a;
    b_next = b;
    k_next = k;
    done   = 1'b0;
    result = '0;
    if (a == '0) begin
      done   = 1'b1;
      result = b << k;
    end else if (b == '0) begin
      done   = 1'b1;
      result = a << k;
    end else if (!a[0] && !b[0]) begin
      a_next = a >> 1;
      b_next = b >> 1;
      k_next = k + KW'(1);
    end else if (!a[0]) begin
      a_next = a >> 1;
    end else if (!b[0]) begin
      b_next = b >> 1;
    end else if (a >= b) begin
      // Difference of two odd values is even, so the halving is exact.
      a_next = (a - b) >> 1;
    end else begin
      b_next = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_seq_top.sv
// Multi-operand GCD engine: folds a req/ack operand stream into a running GCD,
// one Stein step per clock, reporting the step count of the latest operand.
module gcd_seq_top
  import gcd_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          last,
  input  logic [W-1:0]  AB,
  output logic          ack,
  output logic [W-1:0]  C,
  output logic [CW-1:0] cycles
);

  localparam int KW = k_width(W);
  localparam logic [CW-1:0] CYC_MAX = '1;

  state_t        state_reg;
  logic [W-1:0]  acc_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [KW-1:0] k_reg;
  logic          first_reg;
  logic          last_q_reg;
  logic          ack_reg;
  logic [W-1:0]  c_reg;
  logic [CW-1:0] cycles_reg;

  logic [W-1:0]  a_next;
  logic [W-1:0]  b_next;
  logic [KW-1:0] k_next;
  logic          step_done;
  logic [W-1:0]  step_result;

  gcd_stein_step #(
    .W (W),
    .KW(KW)
  ) u_step (
    .a     (a_reg),
    .b     (b_reg),
    .k     (k_reg),
    .a_next(a_next),
    .b_next(b_next),
    .k_next(k_next),
    .done  (step_done),
    .result(step_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      k_reg      <= '0;
      first_reg  <= 1'b1;
      last_q_reg <= 1'b0;
      ack_reg    <= 1'b0;
      c_reg      <= '0;
      cycles_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            last_q_reg <= last;
            cycles_reg <= '0;
            if (first_reg) begin
              acc_reg   <= AB;
              c_reg     <= AB;
              ack_reg   <= 1'b1;
              state_reg <= ACK;
            end else begin
              a_reg     <= acc_reg;
              b_reg     <= AB;
              k_reg     <= '0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          if (cycles_reg != CYC_MAX)
            cycles_reg <= cycles_reg + CW'(1);
          if (step_done) begin
            acc_reg   <= step_result;
            c_reg     <= step_result;
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end else begin
            a_reg <= a_next;
            b_reg <= b_next;
            k_reg <= k_next;
          end
        end
        ACK: begin
          // A closed sequence makes the next operand start a fresh one.
          if (!req) begin
            ack_reg   <= 1'b0;
            first_reg <= last_q_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack    = ack_reg;
  assign C      = c_reg;
  assign cycles = cycles_reg;

endmodule
